// File: rtl/softmax_exp_align.sv
// softmax_exp_align: orders two sign/exponent/mantissa operands by magnitude and
// right-shifts the smaller mantissa one bit per cycle onto the larger exponent.
module softmax_exp_align #(
   parameter int MAN_W = 8,
   parameter int EXP_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a_sign,
   input  logic             b_sign,
   input  logic [EXP_W-1:0] a_exp,
   input  logic [EXP_W-1:0] b_exp,
   input  logic [MAN_W-1:0] a_man,
   input  logic [MAN_W-1:0] b_man,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MAN_W-1:0] man_a,
   output logic [MAN_W-1:0] man_b,
   output logic [EXP_W-1:0] exp_out,
   output logic             condition,
   output logic             sign_out,
   output logic             zero_out
);
   typedef enum logic [1:0] {IDLE, CMP, SHIFT, HOLD} state_t;
   state_t state, state_n;
   logic             la_sign, lb_sign, a_big, big_sign, cond_n, flush, zero_n, enter_hold;
   logic [EXP_W-1:0] la_exp, lb_exp, big_exp, small_exp, d, cnt;
   logic [MAN_W-1:0] la_man, lb_man, big_man, small_man, sr, mb_n;
   // Latched operands stay stable for the whole operation, so the ordering
   // can be recomputed combinationally in every state.
   always_comb begin
      a_big      = (la_exp > lb_exp) || (la_exp == lb_exp && la_man >= lb_man);
      big_exp    = a_big ? la_exp : lb_exp;
      small_exp  = a_big ? lb_exp : la_exp;
      big_man    = a_big ? la_man : lb_man;
      small_man  = a_big ? lb_man : la_man;
      big_sign   = a_big ? la_sign : lb_sign;
      cond_n     = la_sign == lb_sign;
      d          = big_exp - small_exp;
      flush      = d >= EXP_W'(MAN_W);
      mb_n       = (state == CMP) ? (flush ? '0 : small_man) : sr >> 1;
      zero_n     = (!cond_n && big_man == mb_n) || (big_man == '0 && mb_n == '0);
      enter_hold = state_n == HOLD && state != HOLD;
   end
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    state_n = in_valid ? CMP : IDLE;
         CMP:     state_n = (d == '0 || flush) ? HOLD : SHIFT;
         SHIFT:   state_n = (cnt == EXP_W'(1)) ? HOLD : SHIFT;
         HOLD:    state_n = out_ready ? IDLE : HOLD;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_n;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         man_a     <= '0;
         man_b     <= '0;
         exp_out   <= '0;
         condition <= 1'b0;
         sign_out  <= 1'b0;
         zero_out  <= 1'b0;
      end else begin
         in_ready  <= state_n == IDLE;
         out_valid <= state_n == HOLD;
         if (state == IDLE && in_valid) begin
            la_sign <= a_sign;
            lb_sign <= b_sign;
            la_exp  <= a_exp;
            lb_exp  <= b_exp;
            la_man  <= a_man;
            lb_man  <= b_man;
         end
         if (state == CMP) begin
            man_a     <= big_man;
            exp_out   <= big_exp;
            condition <= cond_n;
            sr        <= small_man;
            cnt       <= d;
         end
         if (state == SHIFT) begin
            sr  <= sr >> 1;
            cnt <= cnt - EXP_W'(1);
         end
         if (enter_hold) begin
            man_b    <= mb_n;
            zero_out <= zero_n;
            sign_out <= zero_n ? 1'b0 : big_sign;
         end
      end
   end
endmodule
